// File: rtl/dsp48a1_mac_sequencer_if.sv
// Port bundle for the DSP48A1 MAC sequencer: operand stream, DSP slice connection and result port.
// s_sub is present only when DSP_MAC_SEQ_SUB_EN is defined.
interface dsp48a1_mac_sequencer_if #(
  parameter int CNT_W = 16
);
  logic [17:0]      s_a;
  logic [17:0]      s_b;
  logic             s_valid;
  logic             s_last;
  logic             s_ready;
`ifdef DSP_MAC_SEQ_SUB_EN
  logic             s_sub;
`endif
  logic [17:0]      dsp_a;
  logic [17:0]      dsp_b;
  logic [7:0]       dsp_opmode;
  logic             dsp_cep;
  logic             dsp_rst;
  logic [47:0]      dsp_p;
  logic [47:0]      res;
  logic [CNT_W-1:0] res_len;
  logic             res_valid;
  logic             res_ready;
  logic             busy;

  // Sequencer side
  modport slave (
    input  s_a, s_b, s_valid, s_last,
`ifdef DSP_MAC_SEQ_SUB_EN
    input  s_sub,
`endif
    input  dsp_p, res_ready,
    output s_ready, dsp_a, dsp_b, dsp_opmode, dsp_cep, dsp_rst,
    output res, res_len, res_valid, busy
  );

  // Host / DSP side
  modport master (
    output s_a, s_b, s_valid, s_last,
`ifdef DSP_MAC_SEQ_SUB_EN
    output s_sub,
`endif
    output dsp_p, res_ready,
    input  s_ready, dsp_a, dsp_b, dsp_opmode, dsp_cep, dsp_rst,
    input  res, res_len, res_valid, busy
  );
endinterface

// File: rtl/dsp48a1_mac_sequencer.sv
// Drives one DSP48A1 slice as a multiply-accumulator over a framed (A,B) stream and returns the dot product.
// Optional subtract beats are enabled by defining DSP_MAC_SEQ_SUB_EN.
module dsp48a1_mac_sequencer #(
  parameter int PIPE_LAT    = 3,
  parameter int OPMODE_SKEW = 1,
  parameter int CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  dsp48a1_mac_sequencer_if.slave bus
);
  localparam int               DEPTH    = PIPE_LAT - 1;
  localparam int               DW       = $clog2(PIPE_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [7:0]       OP_FIRST = 8'h01;
  localparam logic [7:0]       OP_ACC   = 8'h09;
  localparam logic [7:0]       OP_HOLD  = 8'h08;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, HOLD} state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [DW-1:0]    drain_reg, drain_next;
  logic [47:0]      res_reg, res_next;
  logic [CNT_W-1:0] res_len_reg, res_len_next;
  logic [17:0]      a_reg, b_reg;
  logic [DEPTH-1:0] vld_pipe;
  logic [7:0]       op_pipe [DEPTH];
  logic [7:0]       opmode_reg;
  logic             cep_reg;
  logic             ready;
  logic             accept;
  logic             beat_sub;
  logic [7:0]       beat_op;

`ifdef DSP_MAC_SEQ_SUB_EN
  assign beat_sub = bus.s_sub;
`else
  assign beat_sub = 1'b0;
`endif

  assign ready   = (state_reg == IDLE) || (state_reg == RUN);
  assign accept  = bus.s_valid && ready;
  // The first beat of a vector ignores P (Z=0) so no explicit accumulator clear is needed
  assign beat_op = (state_reg == IDLE) ? (OP_FIRST | {beat_sub, 7'b0})
                                       : (OP_ACC   | {beat_sub, 7'b0});

  // Beat delay line: stage k holds the beat issued k cycles ago
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe   <= '0;
      for (int k = 0; k < DEPTH; k++) op_pipe[k] <= '0;
      opmode_reg <= '0;
      cep_reg    <= 1'b0;
      a_reg      <= '0;
      b_reg      <= '0;
    end else begin
      vld_pipe[0] <= accept;
      op_pipe[0]  <= beat_op;
      for (int k = 1; k < DEPTH; k++) begin
        vld_pipe[k] <= vld_pipe[k-1];
        op_pipe[k]  <= op_pipe[k-1];
      end
      opmode_reg <= vld_pipe[OPMODE_SKEW-1] ? op_pipe[OPMODE_SKEW-1] : OP_HOLD;
      cep_reg    <= vld_pipe[DEPTH-1];
      if (accept) begin
        a_reg <= bus.s_a;
        b_reg <= bus.s_b;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      drain_reg   <= '0;
      res_reg     <= '0;
      res_len_reg <= '0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      drain_reg   <= drain_next;
      res_reg     <= res_next;
      res_len_reg <= res_len_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    drain_next   = drain_reg;
    res_next     = res_reg;
    res_len_next = res_len_reg;
    unique case (state_reg)
      IDLE: begin
        if (accept) begin
          cnt_next   = '0;
          drain_next = '0;
          state_next = bus.s_last ? DRAIN : RUN;
        end
      end
      RUN: begin
        if (accept) begin
          if (cnt_reg != CNT_MAX) cnt_next = cnt_reg + CNT_W'(1);
          if (bus.s_last) begin
            drain_next = '0;
            state_next = DRAIN;
          end
        end
      end
      DRAIN: begin
        // P carries the final beat once its CEP slot has been clocked
        if (drain_reg == DW'(PIPE_LAT)) begin
          res_next     = bus.dsp_p;
          res_len_next = (cnt_reg == CNT_MAX) ? CNT_MAX : cnt_reg + CNT_W'(1);
          state_next   = HOLD;
        end else begin
          drain_next = drain_reg + DW'(1);
        end
      end
      HOLD: begin
        if (bus.res_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.s_ready    = ready;
  assign bus.dsp_a      = a_reg;
  assign bus.dsp_b      = b_reg;
  assign bus.dsp_opmode = opmode_reg;
  assign bus.dsp_cep    = cep_reg;
  assign bus.dsp_rst    = rst;
  assign bus.res        = res_reg;
  assign bus.res_len    = res_len_reg;
  assign bus.res_valid  = (state_reg == HOLD);
  assign bus.busy       = (state_reg != IDLE);
endmodule

// File: tb/tb_dsp48a1_mac_sequencer.sv
// Bench for dsp48a1_mac_sequencer: behavioural DSP48A1 slice, timing/result scoreboard and directed plus random vectors.
// Subtract tests run when DSP_MAC_SEQ_SUB_EN is defined.
module tb_dsp48a1_mac_sequencer;
  localparam int               CNT_W   = 16;
  localparam logic [CNT_W-1:0] LEN_MAX = '1;
  localparam int               NRAND   = 30;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  bit   cur_sub = 1'b0;
  bit   rr_rand = 1'b0;
  bit   rr_level = 1'b1;

  dsp48a1_mac_sequencer_if #(.CNT_W(CNT_W)) bus ();

  dsp48a1_mac_sequencer #(.PIPE_LAT(3), .OPMODE_SKEW(1), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

`ifdef DSP_MAC_SEQ_SUB_EN
  localparam bit HAS_SUB = 1'b1;
  assign bus.s_sub = cur_sub;
`else
  localparam bit HAS_SUB = 1'b0;
`endif

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural DSP48A1 slice: A1/B1, M, OPMODE and P registers, CEP gating P only
  logic [17:0] d_a1, d_b1;
  logic [47:0] d_m, d_p;
  logic [7:0]  d_op;

  function automatic logic [47:0] dsp_alu(input logic [7:0] op, input logic [47:0] m, input logic [47:0] p);
    logic [47:0] x, z;
    x = (op[1:0] == 2'b01) ? m : 48'd0;
    z = (op[3:2] == 2'b10) ? p : 48'd0;
    return op[7] ? z - x : z + x;
  endfunction

  always @(posedge clk) begin
    if (bus.dsp_rst) begin
      d_a1 <= '0; d_b1 <= '0; d_m <= '0; d_p <= '0; d_op <= '0;
    end else begin
      d_a1 <= bus.dsp_a;
      d_b1 <= bus.dsp_b;
      d_m  <= 48'(d_a1) * 48'(d_b1);
      d_op <= bus.dsp_opmode;
      if (bus.dsp_cep) d_p <= dsp_alu(d_op, d_m, d_p);
    end
  end
  assign bus.dsp_p = d_p;

  always @(posedge clk) begin
    #1;
    bus.res_ready = rr_rand ? 1'($urandom_range(0, 1)) : rr_level;
  end

  // Reference model: per-cycle history of accepted beats plus a queue of expected vector results
  logic [47:0]      exp_res_q [$];
  logic [CNT_W-1:0] exp_len_q [$];
  logic [47:0]      got_res_q [$];
  logic [CNT_W-1:0] got_len_q [$];
  logic [7:0]       op_log [$];
  int               cep_cnt = 0;
  bit               m_open = 1'b0, m_closed = 1'b0;
  logic [47:0]      m_sum = '0;
  int               m_n = 0, last_cyc = 0, cyc = 0;
  bit               acc_h [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
  bit               rst_h [4] = '{1'b1, 1'b1, 1'b1, 1'b1};
  logic [7:0]       op_h  [4] = '{8'h0, 8'h0, 8'h0, 8'h0};
  logic [17:0]      a_h1 = '0, b_h1 = '0;

  always @(negedge clk) begin
    bit          exp_ready, exp_valid, exp_cep, acc_now, first, sub_now;
    logic [7:0]  exp_op, op_now;
    logic [47:0] prod;
    exp_ready = !m_closed;
    exp_valid = m_closed && (cyc >= last_cyc + 5);
    exp_op    = rst_h[1] ? 8'h00 : (acc_h[2] ? op_h[2] : 8'h08);
    exp_cep   = !rst_h[1] && !rst_h[2] && acc_h[3];

    chk("dsp_rst",    64'(bus.dsp_rst),    64'(rst));
    chk("s_ready",    64'(bus.s_ready),    64'(exp_ready));
    chk("busy",       64'(bus.busy),       64'(m_open || m_closed));
    chk("res_valid",  64'(bus.res_valid),  64'(exp_valid));
    chk("dsp_opmode", 64'(bus.dsp_opmode), 64'(exp_op));
    chk("dsp_cep",    64'(bus.dsp_cep),    64'(exp_cep));
    if (acc_h[1]) begin
      chk("dsp_a", 64'(bus.dsp_a), 64'(a_h1));
      chk("dsp_b", 64'(bus.dsp_b), 64'(b_h1));
    end
    if (bus.dsp_opmode != 8'h08 && bus.dsp_opmode != 8'h00) op_log.push_back(bus.dsp_opmode);
    if (bus.dsp_cep) cep_cnt++;

    if (exp_valid && exp_res_q.size() > 0) begin
      chk("res",     64'(bus.res),     64'(exp_res_q[0]));
      chk("res_len", 64'(bus.res_len), 64'(exp_len_q[0]));
      if (bus.res_ready) begin
        got_res_q.push_back(bus.res);
        got_len_q.push_back(bus.res_len);
        void'(exp_res_q.pop_front());
        void'(exp_len_q.pop_front());
        m_closed = 1'b0;
      end
    end

    sub_now = cur_sub && HAS_SUB;
    acc_now = bus.s_valid && exp_ready && !rst;
    first   = !m_open && !m_closed;
    op_now  = first ? 8'h01 : 8'h09;
    if (sub_now) op_now[7] = 1'b1;
    if (acc_now) begin
      prod = 48'(bus.s_a) * 48'(bus.s_b);
      if (first) begin m_sum = '0; m_n = 0; end
      m_sum = sub_now ? m_sum - prod : m_sum + prod;
      m_n++;
      m_open = 1'b1;
      if (bus.s_last) begin
        m_open   = 1'b0;
        m_closed = 1'b1;
        last_cyc = cyc;
        exp_res_q.push_back(m_sum);
        exp_len_q.push_back((m_n > int'(LEN_MAX)) ? LEN_MAX : CNT_W'(m_n));
      end
    end
    if (rst) begin
      m_open = 1'b0; m_closed = 1'b0;
      exp_res_q.delete(); exp_len_q.delete();
    end
    for (int k = 3; k > 1; k--) begin
      acc_h[k] = acc_h[k-1]; rst_h[k] = rst_h[k-1]; op_h[k] = op_h[k-1];
    end
    acc_h[1] = acc_now; rst_h[1] = rst; op_h[1] = op_now;
    a_h1 = bus.s_a; b_h1 = bus.s_b;
    cyc++;
  end

  task automatic drive_beat(input logic [17:0] a, input logic [17:0] b, input bit last, input bit sub);
    int n = 0;
    bus.s_a = a; bus.s_b = b; bus.s_last = last; cur_sub = sub; bus.s_valid = 1'b1;
    @(negedge clk);
    while (!bus.s_ready && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) chk("s_ready_timeout", 64'(bus.s_ready), 64'(1));
    @(posedge clk); #1;
    bus.s_valid = 1'b0;
  endtask

  task automatic gap(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_result(output logic [47:0] r, output logic [CNT_W-1:0] l);
    int n = 0;
    while (got_res_q.size() == 0 && n < 100) begin @(negedge clk); n++; end
    if (got_res_q.size() == 0) begin
      chk("result_timeout", 64'(got_res_q.size()), 64'(1));
      r = '0; l = '0;
    end else begin
      r = got_res_q.pop_front();
      l = got_len_q.pop_front();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [47:0]      r;
    logic [CNT_W-1:0] l;
    int               len, n;
    bus.s_valid = 1'b0; bus.s_a = '0; bus.s_b = '0; bus.s_last = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset in the middle of a vector
    drive_beat(18'd100, 18'd200, 1'b0, 1'b0);
    drive_beat(18'd300, 18'd400, 1'b0, 1'b0);
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("rst_res_valid", 64'(bus.res_valid), 64'(0));
      chk("rst_s_ready",   64'(bus.s_ready),   64'(1));
      chk("rst_dsp_rst",   64'(bus.dsp_rst),   64'(1));
      @(posedge clk); #1;
    end
    rst = 1'b0;
    gap(2);

    // Back-to-back vector after the reset
    op_log.delete();
    drive_beat(18'd3, 18'd4, 1'b0, 1'b0);
    drive_beat(18'd5, 18'd6, 1'b0, 1'b0);
    drive_beat(18'd7, 18'd8, 1'b1, 1'b0);
    wait_result(r, l);
    chk("t2_res", 64'(r), 64'(48'd98));
    chk("t2_len", 64'(l), 64'(3));
    chk("t2_op_count", 64'(op_log.size()), 64'(3));
    chk("t2_op0", 64'(op_log[0]), 64'(8'h01));
    chk("t2_op1", 64'(op_log[1]), 64'(8'h09));
    chk("t2_op2", 64'(op_log[2]), 64'(8'h09));

    // Same vector with two-cycle bubbles between beats
    cep_cnt = 0;
    drive_beat(18'd3, 18'd4, 1'b0, 1'b0); gap(2);
    drive_beat(18'd5, 18'd6, 1'b0, 1'b0); gap(2);
    drive_beat(18'd7, 18'd8, 1'b1, 1'b0);
    wait_result(r, l);
    chk("t3_res", 64'(r), 64'(48'd98));
    chk("t3_cep_count", 64'(cep_cnt), 64'(3));

    // Single full-scale beat: (2^18-1)^2 = 2^36 - 2^19 + 1
    drive_beat(18'h3FFFF, 18'h3FFFF, 1'b1, 1'b0);
    wait_result(r, l);
    chk("t4_res", 64'(r), 64'(48'hF_FFF8_0001));
    chk("t4_len", 64'(l), 64'(1));

    // Consumer stalls 5+ cycles while the next vector is already offered
    rr_level = 1'b0;
    drive_beat(18'd1, 18'd2, 1'b0, 1'b0);
    drive_beat(18'd3, 18'd4, 1'b1, 1'b0);
    fork
      begin
        n = 0;
        @(negedge clk);
        while (!bus.res_valid && n < 50) begin @(negedge clk); n++; end
        chk("t5_res_valid", 64'(bus.res_valid), 64'(1));
        repeat (5) begin
          @(negedge clk);
          chk("t5_hold_s_ready", 64'(bus.s_ready), 64'(0));
        end
        @(posedge clk);
        rr_level = 1'b1;
      end
      begin
        drive_beat(18'd5, 18'd6, 1'b0, 1'b0);
        drive_beat(18'd7, 18'd8, 1'b1, 1'b0);
      end
    join
    wait_result(r, l);
    chk("t5_res_a", 64'(r), 64'(48'd14));
    chk("t5_len_a", 64'(l), 64'(2));
    wait_result(r, l);
    chk("t5_res_b", 64'(r), 64'(48'd86));
    chk("t5_len_b", 64'(l), 64'(2));

`ifdef DSP_MAC_SEQ_SUB_EN
    drive_beat(18'd10, 18'd10, 1'b0, 1'b0);
    drive_beat(18'd2, 18'd3, 1'b1, 1'b1);
    wait_result(r, l);
    chk("t6_res", 64'(r), 64'(48'd94));
    drive_beat(18'd1, 18'd1, 1'b1, 1'b1);
    wait_result(r, l);
    chk("t6_neg", 64'(r), 64'(48'hFFFF_FFFF_FFFF));
    chk("t6_len", 64'(l), 64'(1));
`endif

    // Random vectors, random bubbles, random consumer back-pressure
    got_res_q.delete(); got_len_q.delete();
    rr_rand = 1'b1;
    for (int v = 0; v < NRAND; v++) begin
      len = $urandom_range(1, 6);
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 2) == 0) gap($urandom_range(1, 3));
        drive_beat(($urandom_range(0, 3) == 0) ? 18'h3FFFF : 18'($urandom),
                   ($urandom_range(0, 3) == 0) ? 18'h3FFFF : 18'($urandom),
                   k == len - 1,
                   HAS_SUB && ($urandom_range(0, 1) == 1));
      end
    end
    n = 0;
    while (exp_res_q.size() > 0 && n < 300) begin @(negedge clk); n++; end
    chk("rand_drained", 64'(exp_res_q.size()), 64'(0));
    chk("rand_count",   64'(got_res_q.size()), 64'(NRAND));
    rr_rand = 1'b0;
    gap(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
